// File: rtl/dram_arbiter.sv
// Two-port round-robin front end for the single-port 64-bit data DRAM.
// p0 is the core LSU and p1 is debug/DMA. Each request is range-checked and
// alignment-checked. Loads return an extended lane. Sub-word stores are done
// as a read-modify-write pair of cycles. Full-word stores write directly in RD.
module dram_arbiter #(
    parameter logic [63:0] BASE   = 64'h8000_0000,
    parameter int          ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [2:0]        p0_rd_ctrl,
    input  logic [2:0]        p0_wr_ctrl,
    input  logic [63:0]       p0_addr,
    input  logic [63:0]       p0_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [63:0]       p0_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [2:0]        p1_rd_ctrl,
    input  logic [2:0]        p1_wr_ctrl,
    input  logic [63:0]       p1_addr,
    input  logic [63:0]       p1_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [63:0]       p1_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [2:0] WR_SD  = 3'd4;

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;     // port that wins a tie
    logic              port_q;
    logic [2:0]        rd_q, wr_q;
    logic [1:0]        sz_q;               // log2 of access size in bytes
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] idx_q;
    logic [63:0]       wdata_q;
    logic              err_q;
    logic [63:0]       rdata_q;
    logic [63:0]       old_q;

    logic              gnt_fire;
    logic              gnt_port;
    logic [2:0]        sel_rd, sel_wr;
    logic [63:0]       sel_addr, sel_wdata;
    logic [60:0]       word_rel;
    logic              range_err, ctrl_err, align_err, dec_err;
    logic [1:0]        sel_sz;
    logic [63:0]       rd_shift, ld_val;
    logic [63:0]       wr_shift, merged;
    logic [3:0]        lane_end;
    logic [7:0]        lane_sel;
    logic              rsp_ready_sel;

    // Grant only from IDLE; on a tie the port not granted last wins.
    assign gnt_fire     = (state_q == S_IDLE) && (p0_req_valid || p1_req_valid);
    assign gnt_port     = (p0_req_valid && p1_req_valid) ? prio_q : p1_req_valid;
    assign p0_req_ready = gnt_fire && !gnt_port;
    assign p1_req_ready = gnt_fire && gnt_port;

    assign sel_rd    = gnt_port ? p1_rd_ctrl : p0_rd_ctrl;
    assign sel_wr    = gnt_port ? p1_wr_ctrl : p0_wr_ctrl;
    assign sel_addr  = gnt_port ? p1_addr    : p0_addr;
    assign sel_wdata = gnt_port ? p1_wdata   : p0_wdata;

    // BASE is the byte address of word 0, so it is word aligned and the
    // word index can be formed from the upper address bits alone.
    assign word_rel  = sel_addr[63:3] - BASE[63:3];
    assign range_err = (sel_addr < BASE) || (word_rel[60:ADDR_W] != '0);

    // Decode the ctrl fields into an access size and a ctrl error.
    always_comb begin
        sel_sz   = 2'd0;
        ctrl_err = 1'b0;
        if (sel_rd != 3'd0 && sel_wr != 3'd0) begin
            ctrl_err = 1'b1;
        end else if (sel_rd != 3'd0) begin
            case (sel_rd)
                3'd1, 3'd2: sel_sz = 2'd0;
                3'd3, 3'd4: sel_sz = 2'd1;
                3'd5, 3'd6: sel_sz = 2'd2;
                default:    sel_sz = 2'd3;
            endcase
        end else begin
            case (sel_wr)
                3'd1:    sel_sz = 2'd0;
                3'd2:    sel_sz = 2'd1;
                3'd3:    sel_sz = 2'd2;
                3'd4:    sel_sz = 2'd3;
                default: ctrl_err = 1'b1;
            endcase
        end
    end

    // Natural alignment of the access for its size.
    always_comb begin
        case (sel_sz)
            2'd1:    align_err = sel_addr[0];
            2'd2:    align_err = |sel_addr[1:0];
            2'd3:    align_err = |sel_addr[2:0];
            default: align_err = 1'b0;
        endcase
    end

    assign dec_err = range_err || ctrl_err || align_err;

    // Load path: shift the addressed lane down and extend per the load type.
    assign rd_shift = ram_rdata >> {off_q, 3'b000};

    // Sign or zero extension of the shifted lane.
    always_comb begin
        case (rd_q)
            3'd1:    ld_val = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'd2:    ld_val = {56'd0, rd_shift[7:0]};
            3'd3:    ld_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    ld_val = {48'd0, rd_shift[15:0]};
            3'd5:    ld_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'd6:    ld_val = {32'd0, rd_shift[31:0]};
            default: ld_val = rd_shift;
        endcase
    end

    // Store merge: replace lanes [off .. off+size-1] of the old word.
    assign wr_shift = wdata_q << {off_q, 3'b000};
    assign lane_end = {1'b0, off_q} + (4'd1 << sz_q);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_sel[gi] = (4'(gi) >= {1'b0, off_q}) && (4'(gi) < lane_end);
            assign merged[8*gi +: 8] = lane_sel[gi] ? wr_shift[8*gi +: 8] : old_q[8*gi +: 8];
        end
    endgenerate

    assign rsp_ready_sel = port_q ? p1_rsp_ready : p0_rsp_ready;

    // Next-state and tie-pointer logic.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_fire) begin
                    state_d = dec_err ? S_RESP : S_RD;
                    prio_d  = ~gnt_port;
                end
            end
            S_RD:    state_d = (wr_q != 3'd0 && wr_q != WR_SD) ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            default: if (rsp_ready_sel) state_d = S_IDLE;
        endcase
    end

    // DRAM side: address only while accessing, write in RD for SD or in WR.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state_q == S_RD) begin
            ram_addr = idx_q;
            if (wr_q == WR_SD) begin
                ram_we    = 1'b1;
                ram_wdata = wdata_q;
            end
        end else if (state_q == S_WR) begin
            ram_addr  = idx_q;
            ram_we    = 1'b1;
            ram_wdata = merged;
        end
    end

    assign p0_rsp_valid = (state_q == S_RESP) && !port_q;
    assign p1_rsp_valid = (state_q == S_RESP) && port_q;
    assign p0_rdata     = p0_rsp_valid ? rdata_q : '0;
    assign p1_rdata     = p1_rsp_valid ? rdata_q : '0;
    assign p0_rsp_err   = p0_rsp_valid && err_q;
    assign p1_rsp_err   = p1_rsp_valid && err_q;

    // State, request latch on grant, and load/old-word capture in RD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            port_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            sz_q    <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (gnt_fire) begin
                port_q  <= gnt_port;
                rd_q    <= sel_rd;
                wr_q    <= sel_wr;
                sz_q    <= sel_sz;
                off_q   <= sel_addr[2:0];
                idx_q   <= word_rel[ADDR_W-1:0];
                wdata_q <= sel_wdata;
                err_q   <= dec_err;
                rdata_q <= '0;
            end
            if (state_q == S_RD) begin
                if (rd_q != 3'd0) begin
                    rdata_q <= ld_val;
                end else begin
                    old_q <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a DRAM model, a queue-fed requester per port, and a
// transaction-level reference that predicts grants, responses and RAM writes.
module tb_dram_arbiter;

    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam int          ADDR_W = 13;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        vld [2];
    logic [2:0]  rdc [2];
    logic [2:0]  wrc [2];
    logic [63:0] adr [2];
    logic [63:0] wd  [2];
    logic        rsr [2];

    logic              p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
    logic              p0_rsp_err, p1_rsp_err;
    logic [63:0]       p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [63:0]       ram_wdata, ram_rdata;

    logic [63:0] mem     [DEPTH];
    logic [63:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    dram_arbiter #(.BASE(BASE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(vld[0]), .p0_req_ready(p0_req_ready), .p0_rd_ctrl(rdc[0]),
        .p0_wr_ctrl(wrc[0]), .p0_addr(adr[0]), .p0_wdata(wd[0]),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(rsr[0]), .p0_rdata(p0_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(vld[1]), .p1_req_ready(p1_req_ready), .p1_rd_ctrl(rdc[1]),
        .p1_wr_ctrl(wrc[1]), .p1_addr(adr[1]), .p1_wdata(wd[1]),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(rsr[1]), .p1_rdata(p1_rdata),
        .p1_rsp_err(p1_rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // DRAM macro: async read, write on the rising edge.
    assign ram_rdata = mem[ram_addr];
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 64'd0;
            ref_mem[i] = 64'd0;
        end
        mem[0]     = 64'h8877_6655_4433_2211;
        ref_mem[0] = 64'h8877_6655_4433_2211;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] = ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a request must produce, from the access rules alone.
    function automatic void predict(input logic [2:0] rd, input logic [2:0] wr,
                                    input logic [63:0] addr, input logic [63:0] wdata,
                                    output logic err, output logic [63:0] rdata,
                                    output int lat, output int kind,
                                    output logic [ADDR_W-1:0] idx, output logic [63:0] neww);
        int size, off;
        logic sgn;
        logic [63:0] word, widx;
        err = 1'b0; rdata = 64'd0; kind = 0; size = 1; sgn = 1'b0;
        neww = 64'd0; idx = '0; lat = 1;
        if (rd != 3'd0 && wr != 3'd0) err = 1'b1;
        else if (rd != 3'd0) begin
            size = (rd == 3'd7) ? 8 : (rd >= 3'd5) ? 4 : (rd >= 3'd3) ? 2 : 1;
            sgn  = (rd == 3'd1 || rd == 3'd3 || rd == 3'd5);
        end else if (wr >= 3'd1 && wr <= 3'd4) begin
            size = 1 << (int'(wr) - 1);
            kind = (wr == 3'd4) ? 1 : 2;
        end else err = 1'b1;
        if (addr < BASE) err = 1'b1;
        else begin
            widx = (addr - BASE) >> 3;
            if (widx >= 64'(DEPTH)) err = 1'b1;
            else idx = widx[ADDR_W-1:0];
        end
        off = int'(addr[2:0]);
        if (off % size != 0) err = 1'b1;
        if (err) return;
        word = ref_mem[idx];
        if (kind == 0) begin
            for (int i = 0; i < size; i++) rdata[8*i +: 8] = word[8*(off+i) +: 8];
            if (sgn && rdata[8*size-1])
                for (int i = size; i < 8; i++) rdata[8*i +: 8] = 8'hFF;
            lat = 2;
        end else begin
            neww = word;
            for (int i = 0; i < size; i++) neww[8*(off+i) +: 8] = wdata[8*i +: 8];
            lat = (kind == 1) ? 2 : 3;
        end
    endfunction

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;
    req_t q0[$];
    req_t q1[$];

    // Model state and observations shared with the directed sequence.
    int                cyc = 0;
    logic              gnt_seen [2];
    logic              m_busy = 1'b0, m_owner = 1'b0, m_prio = 1'b0, m_err = 1'b0;
    logic              m_applied = 1'b0, resp_seen = 1'b0;
    int                m_gnt_cyc = 0, m_t_resp = 0, m_kind = 0, m_lat = 0;
    logic [63:0]       m_rdata = 64'd0, m_neww = 64'd0;
    logic [ADDR_W-1:0] m_idx = '0;
    int                done_cnt [2];
    logic [63:0]       last_rdata [2];
    logic              last_err [2];
    int                last_lat [2];
    int                gnt_cyc_p [2];
    int                hs_cyc_p [2];
    int                we_count = 0;
    logic [63:0]       last_wdata = 64'd0;
    int                gnt_log[$];

    // Per-cycle compare against the reference, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        logic        a_rdy [2];
        logic        a_rsv [2];
        logic        a_err [2];
        logic [63:0] a_rd  [2];
        logic        e_gnt, gp, phase, e_we;
        int          k;
        cyc++;
        a_rdy[0] = p0_req_ready; a_rdy[1] = p1_req_ready;
        a_rsv[0] = p0_rsp_valid; a_rsv[1] = p1_rsp_valid;
        a_err[0] = p0_rsp_err;   a_err[1] = p1_rsp_err;
        a_rd[0]  = p0_rdata;     a_rd[1]  = p1_rdata;
        if (ram_we) begin
            we_count++;
            last_wdata = ram_wdata;
        end
        if (!rst) begin
            m_busy = 1'b0;
            m_prio = 1'b0;
            for (int p = 0; p < 2; p++) begin
                chk("rst_req_ready", 64'(a_rdy[p]), 64'd0);
                chk("rst_rsp_valid", 64'(a_rsv[p]), 64'd0);
            end
            chk("rst_ram_we", 64'(ram_we), 64'd0);
        end else begin
            e_gnt = !m_busy && (vld[0] || vld[1]);
            gp    = (vld[0] && vld[1]) ? m_prio : vld[1];
            for (int p = 0; p < 2; p++)
                chk("req_ready", 64'(a_rdy[p]), 64'(e_gnt && (int'(gp) == p)));
            phase = m_busy && (cyc >= m_t_resp);
            for (int p = 0; p < 2; p++)
                chk("rsp_valid", 64'(a_rsv[p]), 64'(phase && (int'(m_owner) == p)));
            if (m_busy && !resp_seen && a_rsv[m_owner]) begin
                resp_seen = 1'b1;
                last_lat[m_owner] = cyc - m_gnt_cyc;
            end
            if (phase) begin
                chk("rsp_rdata", a_rd[m_owner], m_rdata);
                chk("rsp_err", 64'(a_err[m_owner]), 64'(m_err));
                chk("resp_ram_we", 64'(ram_we), 64'd0);
                chk("resp_ram_addr", 64'(ram_addr), 64'd0);
                if (!m_applied) begin
                    m_applied = 1'b1;
                    if (!m_err && m_kind != 0) begin
                        ref_mem[m_idx] = m_neww;
                        chk("mem_word", mem[m_idx], m_neww);
                    end
                end
                if (rsr[m_owner]) begin
                    m_busy = 1'b0;
                    done_cnt[m_owner]++;
                    last_rdata[m_owner] = a_rd[m_owner];
                    last_err[m_owner]   = a_err[m_owner];
                    hs_cyc_p[m_owner]   = cyc;
                end
            end else if (m_busy) begin
                k    = cyc - m_gnt_cyc - 1;
                e_we = (m_kind == 1) || (m_kind == 2 && k == 1);
                chk("acc_ram_addr", 64'(ram_addr), 64'(m_idx));
                chk("acc_ram_we", 64'(ram_we), 64'(e_we));
                if (e_we) chk("acc_ram_wdata", ram_wdata, m_neww);
            end else begin
                chk("idle_ram_we", 64'(ram_we), 64'd0);
                chk("idle_ram_addr", 64'(ram_addr), 64'd0);
            end
            if (e_gnt) begin
                gnt_seen[gp] = 1'b1;
                m_prio       = !gp;
                gnt_log.push_back(int'(gp));
                gnt_cyc_p[gp] = cyc;
                predict(rdc[gp], wrc[gp], adr[gp], wd[gp], m_err, m_rdata, m_lat, m_kind, m_idx, m_neww);
                m_busy    = 1'b1;
                m_owner   = gp;
                m_gnt_cyc = cyc;
                m_t_resp  = cyc + m_lat;
                m_applied = 1'b0;
                resp_seen = 1'b0;
            end
        end
    end

    // Requesters: present the head of each queue, pop it after its grant.
    initial begin
        req_t h;
        int   n;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (gnt_seen[p]) begin
                    gnt_seen[p] = 1'b0;
                    if (p == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                n = (p == 0) ? q0.size() : q1.size();
                if (n > 0) begin
                    h = (p == 0) ? q0[0] : q1[0];
                    vld[p] = 1'b1; rdc[p] = h.rd; wrc[p] = h.wr;
                    adr[p] = h.addr; wd[p] = h.wdata;
                end else begin
                    vld[p] = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int p, input logic [2:0] rd, input logic [2:0] wr,
                         input logic [63:0] a, input logic [63:0] w);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = w;
        if (p == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic wait_done(input int p, input int n);
        int t = 0;
        while (done_cnt[p] < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt[p] < n) begin
            checks++;
            errors++;
            $display("FAIL timeout port %0d done %0d want %0d", p, done_cnt[p], n);
        end
    endtask

    task automatic wait_grant(input int g);
        int t = 0;
        while (gnt_log.size() == g && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (gnt_log.size() == g) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout got none want one");
        end
    endtask

    task automatic run(input int p, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [63:0] a, input logic [63:0] w,
                       input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
        int n = done_cnt[p] + 1;
        issue(p, rd, wr, a, w);
        wait_done(p, n);
        $display("txn p%0d rd=%0d wr=%0d addr=%h rdata=%h err=%0b lat=%0d",
                 p, rd, wr, a, last_rdata[p], last_err[p], last_lat[p]);
        chk("lit_rdata", last_rdata[p], exp_rdata);
        chk("lit_err", 64'(last_err[p]), 64'(exp_err));
        chk("lit_latency", 64'(last_lat[p]), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int wc, n0, n1, g;
        logic [63:0] r0;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; rdc[p] = 3'd0; wrc[p] = 3'd0; adr[p] = 64'd0; wd[p] = 64'd0;
            rsr[p] = 1'b1; gnt_seen[p] = 1'b0; done_cnt[p] = 0; last_rdata[p] = 64'd0;
            last_err[p] = 1'b0; last_lat[p] = 0; gnt_cyc_p[p] = 0; hs_cyc_p[p] = 0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", ram_wdata, 64'd0);
        chk("rst_p0_rdata", p0_rdata, 64'd0);
        chk("rst_p1_err", 64'(p1_rsp_err), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Loads with lane extraction
        run(0, 3'd1, 3'd0, 64'h8000_0003, 64'd0, 64'h44, 1'b0, 2);
        run(0, 3'd3, 3'd0, 64'h8000_0006, 64'd0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 2);
        run(0, 3'd6, 3'd0, 64'h8000_0004, 64'd0, 64'h8877_6655, 1'b0, 2);

        // Sub-word store then full read-back
        wc = we_count;
        run(0, 3'd0, 3'd1, 64'h8000_0005, 64'hAB, 64'd0, 1'b0, 3);
        chk("sb_we_count", 64'(we_count - wc), 64'd1);
        chk("sb_wdata", last_wdata, 64'h8877_AB55_4433_2211);
        run(0, 3'd7, 3'd0, BASE, 64'd0, 64'h8877_AB55_4433_2211, 1'b0, 2);

        // Both ports busy: grants must alternate
        g = gnt_log.size();
        n0 = done_cnt[0]; n1 = done_cnt[1];
        issue(0, 3'd7, 3'd0, BASE, 64'd0);
        issue(0, 3'd1, 3'd0, BASE + 64'd1, 64'd0);
        issue(0, 3'd0, 3'd4, BASE + 64'd8, 64'h1111_2222_3333_4444);
        issue(0, 3'd7, 3'd0, BASE + 64'd8, 64'd0);
        issue(1, 3'd5, 3'd0, BASE, 64'd0);
        issue(1, 3'd0, 3'd4, BASE + 64'd16, 64'hDEAD_BEEF_0BAD_F00D);
        issue(1, 3'd7, 3'd0, BASE + 64'd16, 64'd0);
        issue(1, 3'd2, 3'd0, BASE + 64'd7, 64'd0);
        wait_done(0, n0 + 4);
        wait_done(1, n1 + 4);
        chk("rr_grant_count", 64'(gnt_log.size() - g), 64'd8);
        for (int i = g + 1; i < gnt_log.size(); i++)
            chk("rr_alternate", 64'(gnt_log[i]), 64'(1 - gnt_log[i-1]));
        $display("txn rr p0 last=%h p1 last=%h", last_rdata[0], last_rdata[1]);
        chk("rr_p0_ld", last_rdata[0], 64'h1111_2222_3333_4444);
        chk("rr_p1_lbu", last_rdata[1], 64'h88);

        // Decode errors: one-cycle response, no RAM write
        wc = we_count;
        run(0, 3'd7, 3'd0, 64'h7FFF_FFF8, 64'd0, 64'd0, 1'b1, 1);
        run(0, 3'd7, 3'd0, 64'h8001_0000, 64'd0, 64'd0, 1'b1, 1);
        run(1, 3'd5, 3'd0, 64'h8000_0002, 64'd0, 64'd0, 1'b1, 1);
        run(0, 3'd1, 3'd1, BASE, 64'd0, 64'd0, 1'b1, 1);
        chk("err_no_we", 64'(we_count - wc), 64'd0);

        // Back-pressure on p1 while p0 waits
        rsr[1] = 1'b0;
        n0 = done_cnt[0] + 1; n1 = done_cnt[1] + 1;
        g = gnt_log.size();
        issue(1, 3'd7, 3'd0, BASE + 64'd8, 64'd0);
        wait_grant(g);
        issue(0, 3'd1, 3'd0, BASE, 64'd0);
        for (int t = 0; t < 20 && !p1_rsp_valid; t++) @(negedge clk);
        r0 = p1_rdata;
        chk("bp_first_rdata", r0, 64'h1111_2222_3333_4444);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(p1_rsp_valid), 64'd1);
            chk("bp_hold_rdata", p1_rdata, r0);
            chk("bp_p0_ready", 64'(p0_req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsr[1] = 1'b1;
        wait_done(1, n1);
        wait_done(0, n0);
        $display("txn bp p1=%h p0=%h", last_rdata[1], last_rdata[0]);
        chk("bp_p0_grant_gap", 64'(gnt_cyc_p[0] - hs_cyc_p[1]), 64'd1);
        chk("bp_p0_rdata", last_rdata[0], 64'h11);

        // Reset asserted during the WR cycle of an SH
        n0 = done_cnt[0];
        g = gnt_log.size();
        issue(0, 3'd0, 3'd2, BASE + 64'd2, 64'hBEEF);
        wait_grant(g);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wr_we_before_rst", 64'(ram_we), 64'd1);
        chk("wr_wdata_before_rst", ram_wdata, 64'h8877_AB55_BEEF_2211);
        rst = 1'b0;
        #1;
        chk("rst_we_drop", 64'(ram_we), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        chk("rst_no_resp", 64'(done_cnt[0] - n0), 64'd0);
        $display("txn reset during SH, no response");
        run(0, 3'd7, 3'd0, BASE, 64'd0, 64'h8877_AB55_4433_2211, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
